// File: rtl/riscv_v_alu_wb_buffer.sv
// Vector ALU result write-back buffer: DEPTH-entry FIFO draining byte-enabled writes to the VRF.
// Optional build macro RISCV_V_WB_BYPASS_EN adds a zero-latency path when the FIFO is empty.
module riscv_v_alu_wb_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_BYTES  = DATA_WIDTH / 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH+NUM_BYTES-1:0] in_result,
  input  logic [NUM_BYTES-1:0]            in_zf,
  input  logic [NUM_BYTES-1:0]            in_of,
  input  logic [NUM_BYTES-1:0]            in_cf,
  input  logic [ADDR_W-1:0]               in_dst,
  input  logic                            in_wr_flags,
  output logic                            vrf_we,
  input  logic                            vrf_ready,
  output logic [ADDR_W-1:0]               vrf_addr,
  output logic [DATA_WIDTH-1:0]           vrf_wdata,
  output logic [NUM_BYTES-1:0]            vrf_be,
  output logic                            flag_we,
  output logic [NUM_BYTES-1:0]            flag_zf,
  output logic [NUM_BYTES-1:0]            flag_of,
  output logic [NUM_BYTES-1:0]            flag_cf,
  output logic [$clog2(DEPTH):0]          occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its payload stable while valid && !ready, and ready never depends on valid.

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [NUM_BYTES-1:0]  bv_mem   [DEPTH];
  logic [NUM_BYTES-1:0]  zf_mem   [DEPTH];
  logic [NUM_BYTES-1:0]  of_mem   [DEPTH];
  logic [NUM_BYTES-1:0]  cf_mem   [DEPTH];
  logic [ADDR_W-1:0]     dst_mem  [DEPTH];
  logic                  wf_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [DATA_WIDTH-1:0] in_data;
  logic [NUM_BYTES-1:0]  in_bv;
  assign in_data = in_result[DATA_WIDTH+NUM_BYTES-1:NUM_BYTES];
  assign in_bv   = in_result[NUM_BYTES-1:0];

  logic empty, push, fifo_push, fifo_pop, head_done;
  assign empty    = (count == '0);
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;

  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NUM_BYTES-1:0]  head_bv, head_zf, head_of, head_cf;
  logic [ADDR_W-1:0]     head_dst;
  logic                  head_wf;

  always_comb begin
    head_valid = !empty;
    head_data  = data_mem[rd_ptr];
    head_bv    = bv_mem[rd_ptr];
    head_zf    = zf_mem[rd_ptr];
    head_of    = of_mem[rd_ptr];
    head_cf    = cf_mem[rd_ptr];
    head_dst   = dst_mem[rd_ptr];
    head_wf    = wf_mem[rd_ptr];
`ifdef RISCV_V_WB_BYPASS_EN
    // Empty FIFO: the incoming result is offered to the VRF in the same cycle.
    if (empty && in_valid) begin
      head_valid = 1'b1;
      head_data  = in_data;
      head_bv    = in_bv;
      head_zf    = in_zf;
      head_of    = in_of;
      head_cf    = in_cf;
      head_dst   = in_dst;
      head_wf    = in_wr_flags;
    end
`endif
  end

  // An all-zero byte_valid entry is retired without a VRF write.
  assign head_done = head_valid && (!(|head_bv) || vrf_ready);
  assign fifo_pop  = head_done && !empty;
`ifdef RISCV_V_WB_BYPASS_EN
  assign fifo_push = push && !(empty && head_done);
`else
  assign fifo_push = push;
`endif

  assign vrf_we    = head_valid && (|head_bv);
  assign flag_we   = vrf_we && head_wf;
  assign vrf_addr  = vrf_we ? head_dst  : '0;
  assign vrf_wdata = vrf_we ? head_data : '0;
  assign vrf_be    = vrf_we ? head_bv   : '0;
  assign flag_zf   = vrf_we ? (head_zf & head_bv) : '0;
  assign flag_of   = vrf_we ? (head_of & head_bv) : '0;
  assign flag_cf   = vrf_we ? (head_cf & head_bv) : '0;
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      data_mem[wr_ptr] <= in_data;
      bv_mem[wr_ptr]   <= in_bv;
      zf_mem[wr_ptr]   <= in_zf;
      of_mem[wr_ptr]   <= in_of;
      cf_mem[wr_ptr]   <= in_cf;
      dst_mem[wr_ptr]  <= in_dst;
      wf_mem[wr_ptr]   <= in_wr_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_v_alu_wb_buffer.sv
// Bench for riscv_v_alu_wb_buffer: directed scenarios plus random traffic against a queue model.
module tb_riscv_v_alu_wb_buffer;

  localparam int DW    = 128;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int REC_W = 1 + AW + 3 * NB + DW + NB;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW+NB-1:0] in_result;
  logic [NB-1:0]  in_zf, in_of, in_cf;
  logic [AW-1:0]  in_dst;
  logic           in_wr_flags;
  logic           vrf_we;
  logic           vrf_ready;
  logic [AW-1:0]  vrf_addr;
  logic [DW-1:0]  vrf_wdata;
  logic [NB-1:0]  vrf_be;
  logic           flag_we;
  logic [NB-1:0]  flag_zf, flag_of, flag_cf;
  logic [$clog2(DEPTH):0] occupancy;

  riscv_v_alu_wb_buffer #(.DATA_WIDTH(DW), .NUM_BYTES(NB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zf(in_zf), .in_of(in_of), .in_cf(in_cf), .in_dst(in_dst), .in_wr_flags(in_wr_flags),
    .vrf_we(vrf_we), .vrf_ready(vrf_ready), .vrf_addr(vrf_addr), .vrf_wdata(vrf_wdata),
    .vrf_be(vrf_be), .flag_we(flag_we), .flag_zf(flag_zf), .flag_of(flag_of),
    .flag_cf(flag_cf), .occupancy(occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int writes_seen = 0;

  // Expected FIFO contents, oldest first: {wr_flags, dst, zf, of, cf, data, byte_valid}
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference model: a queue of accepted results; the oldest one is what the VRF should see.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      int sz;
      logic consumed;
      sz = exp_q.size();
      consumed = 1'b0;
      if (sz > 0 && (exp_q[0][NB-1:0] == '0 || vrf_ready)) void'(exp_q.pop_front());
`ifdef RISCV_V_WB_BYPASS_EN
      if (sz == 0 && in_valid && (in_result[NB-1:0] == '0 || vrf_ready)) consumed = 1'b1;
`endif
      if (in_valid && sz < DEPTH && !consumed)
        exp_q.push_back({in_wr_flags, in_dst, in_zf, in_of, in_cf, in_result});
    end
  end

  // Scoreboard: compare every output once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      logic [REC_W-1:0] h;
      logic hv, we;
      logic [NB-1:0] bv;
      hv = 1'b0;
      h  = '0;
      if (exp_q.size() > 0) begin
        hv = 1'b1;
        h  = exp_q[0];
      end
`ifdef RISCV_V_WB_BYPASS_EN
      else if (in_valid) begin
        hv = 1'b1;
        h  = {in_wr_flags, in_dst, in_zf, in_of, in_cf, in_result};
      end
`endif
      bv = h[NB-1:0];
      we = hv && (bv != '0);
      check("occupancy", DW'(occupancy), DW'(exp_q.size()));
      check("in_ready",  DW'(in_ready),  DW'(exp_q.size() < DEPTH));
      check("vrf_we",    DW'(vrf_we),    DW'(we));
      check("flag_we",   DW'(flag_we),   DW'(we && h[REC_W-1]));
      check("vrf_addr",  DW'(vrf_addr),  we ? DW'(h[REC_W-2 -: AW]) : '0);
      check("vrf_wdata", vrf_wdata,      we ? h[DW+NB-1:NB] : '0);
      check("vrf_be",    DW'(vrf_be),    we ? DW'(bv) : '0);
      check("flag_cf",   DW'(flag_cf),   we ? DW'(h[DW+2*NB-1 -: NB] & bv) : '0);
      check("flag_of",   DW'(flag_of),   we ? DW'(h[DW+3*NB-1 -: NB] & bv) : '0);
      check("flag_zf",   DW'(flag_zf),   we ? DW'(h[DW+4*NB-1 -: NB] & bv) : '0);
      if (vrf_we && vrf_ready) writes_seen++;
    end
  end

  // driver tasks
  task automatic drive(input logic r, input logic v, input logic [DW-1:0] d, input logic [NB-1:0] bv,
                       input logic [AW-1:0] dst, input logic wf, input logic [NB-1:0] zf,
                       input logic [NB-1:0] of, input logic [NB-1:0] cf, input logic rdy);
    @(posedge clk);
    #1;
    rst         = r;
    in_valid    = v;
    in_result   = {d, bv};
    in_dst      = dst;
    in_wr_flags = wf;
    in_zf       = zf;
    in_of       = of;
    in_cf       = cf;
    vrf_ready   = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, rdy);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [NB-1:0] bv, input logic [AW-1:0] dst,
                      input logic wf, input logic [NB-1:0] cf, input logic rdy);
    drive(1'b0, 1'b1, d, bv, dst, wf, NB'(16'h00FF), NB'(16'h3C3C), cf, rdy);
  endtask

  task automatic random_cycle();
    logic [DW-1:0] d;
    logic [NB-1:0] bv;
    d = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       bv = '0;
      1:       bv = '1;
      default: bv = NB'($urandom);
    endcase
    drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, d, bv, AW'($urandom),
          1'($urandom), NB'($urandom), NB'($urandom), NB'($urandom), $urandom_range(0, 2) != 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_dst = '0; in_wr_flags = 1'b0;
    in_zf = '0; in_of = '0; in_cf = '0; vrf_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2, 1'b0);

    // single write, ready VRF
    push(128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, 5'd3, 1'b0, '0, 1'b1);
    idle(3, 1'b1);

    // fill under back-pressure, fifth push must be ignored, then drain
    for (int i = 0; i < 5; i++)
      push({4{$urandom}}, 16'hFFFF, AW'(i + 8), 1'b0, '0, 1'b0);
    idle(2, 1'b0);
    idle(7, 1'b1);

    // empty byte_valid dropped, partial enable written
    push({4{32'hA5A5_5A5A}}, 16'h0000, 5'd1, 1'b1, '1, 1'b1);
    push({4{32'hDEAD_BEEF}}, 16'h00F0, 5'd2, 1'b0, '1, 1'b1);
    idle(3, 1'b1);

    // flag writes masked by byte_valid
    push({4{32'h1111_2222}}, 16'h0F0F, 5'd4, 1'b1, 16'hFFFF, 1'b1);
    push({4{32'h3333_4444}}, 16'h0F0F, 5'd5, 1'b0, 16'hFFFF, 1'b1);
    idle(3, 1'b1);

    // reset while entries are queued, then recover
    for (int i = 0; i < 3; i++)
      push({4{$urandom}}, 16'hFFFF, AW'(i + 20), 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    idle(2, 1'b0);
    push({4{32'hCAFE_F00D}}, 16'hFFFF, 5'd7, 1'b1, 16'h8001, 1'b1);
    idle(3, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) random_cycle();
    idle(DEPTH + 4, 1'b1);

    check("writes_seen_nonzero", DW'(writes_seen > 20), DW'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
